// File: rtl/ad_start_sched.sv
// ad_start_sched: N_CH phase-locked ADC start-pulse generators.
// Each channel runs a multiplier-free DDA against a threshold derived from the
// measured phase period. Fires pass through a fixed delay line and a pulse
// stretcher before reaching ad_start. All outputs are registered.
module ad_start_sched #(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned FREQ_W    = 16,
   parameter int unsigned PH_W      = 32,
   parameter int unsigned SCALE     = 10,
   parameter int unsigned TRUNC     = 0,
   parameter int unsigned START_DLY = 3,
   parameter int unsigned PULSE_W   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     phase_valid,
   input  logic [PH_W-1:0]          phase_cnt,
   input  logic                     ad_en,
   input  logic [N_CH-1:0]          ch_en,
   input  logic [N_CH*FREQ_W-1:0]   reg_freq,
   output logic [N_CH-1:0]          ad_start,
   output logic                     armed,
   output logic [N_CH-1:0]          ovr
);

   // Threshold width: period times SCALE plus one guard bit.
   localparam int unsigned TW = PH_W + $clog2(SCALE) + 1;
   // Accumulator sum width: acc < T and freq < T, so one extra bit suffices.
   localparam int unsigned SW = TW + 1;
   // The output register itself supplies one cycle of the start delay.
   localparam int unsigned PD = (START_DLY > 1) ? START_DLY - 1 : 1;
   localparam int unsigned CW = $clog2(PULSE_W + 1);

   logic                          armed_q, armed_d;
   logic [TW-1:0]                 thr_q, thr_d;
   logic [N_CH-1:0][FREQ_W-1:0]   freq_sh_q, freq_sh_d;
   logic [N_CH-1:0][TW-1:0]       acc_q, acc_d;
   logic [N_CH-1:0][PD-1:0]       pipe_q, pipe_d;
   logic [N_CH-1:0][CW-1:0]       cnt_q, cnt_d;
   logic [N_CH-1:0]               ovr_q, ovr_d;
   logic [N_CH-1:0]               ad_start_q, ad_start_d;

   logic [PH_W-1:0]               period_new;
   logic [TW-1:0]                 thr_new;
   logic [N_CH-1:0]               fire;
   logic [FREQ_W-1:0]             freq_new;
   logic [SW-1:0]                 sum;
   logic [SW-1:0]                 diff;
   logic                          arrive;
   logic [CW-1:0]                 cnt_nxt;

   // Next-state: arming, shadow capture, per-channel DDA, delay line and stretcher.
   always_comb begin
      period_new = (phase_cnt >> TRUNC) << TRUNC;
      thr_new    = TW'(period_new) * TW'(SCALE);

      armed_d    = armed_q;
      thr_d      = thr_q;
      freq_sh_d  = freq_sh_q;
      acc_d      = acc_q;
      pipe_d     = pipe_q;
      cnt_d      = cnt_q;
      ovr_d      = ovr_q;
      ad_start_d = '0;
      fire       = '0;
      freq_new   = '0;
      sum        = '0;
      diff       = '0;
      arrive     = 1'b0;
      cnt_nxt    = '0;

      if (!ad_en) begin
         // Disarm: drop everything in flight, including the sticky overrun flags.
         armed_d = 1'b0;
         acc_d   = '0;
         pipe_d  = '0;
         cnt_d   = '0;
         ovr_d   = '0;
      end else begin
         if (phase_valid) begin
            armed_d = 1'b1;
            thr_d   = thr_new;
         end

         for (int i = 0; i < N_CH; i++) begin
            freq_new = reg_freq[i*FREQ_W +: FREQ_W];
            sum      = {1'b0, acc_q[i]} + SW'(freq_sh_q[i]);
            diff     = sum - {1'b0, thr_q};

            if (phase_valid) begin
               // Phase event: realign and fire the phase-aligned sample on the new rate.
               freq_sh_d[i] = freq_new;
               acc_d[i]     = '0;
               fire[i]      = ch_en[i] && (freq_new != '0) && (thr_new != '0);
            end else if (armed_q && ch_en[i] && (freq_sh_q[i] != '0) && (thr_q != '0)) begin
               if (TW'(freq_sh_q[i]) >= thr_q) begin
                  // Requested rate exceeds one sample per cycle.
                  fire[i]  = 1'b1;
                  acc_d[i] = '0;
                  ovr_d[i] = 1'b1;
               end else if (sum >= {1'b0, thr_q}) begin
                  fire[i]  = 1'b1;
                  acc_d[i] = diff[TW-1:0];
               end else begin
                  acc_d[i] = sum[TW-1:0];
               end
            end else begin
               acc_d[i] = '0;
            end

            pipe_d[i][0] = fire[i];
            for (int k = 1; k < PD; k++) begin
               pipe_d[i][k] = pipe_q[i][k-1];
            end

            arrive  = (START_DLY > 1) ? pipe_q[i][PD-1] : fire[i];
            cnt_nxt = cnt_q[i];
            if (arrive) begin
               // A fire landing on a live pulse merges into it.
               cnt_nxt = CW'(PULSE_W);
               if (cnt_q[i] != '0) begin
                  ovr_d[i] = 1'b1;
               end
            end else if (cnt_q[i] != '0) begin
               cnt_nxt = cnt_q[i] - CW'(1);
            end
            cnt_d[i]      = cnt_nxt;
            ad_start_d[i] = (cnt_nxt != '0);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed_q    <= 1'b0;
         thr_q      <= '0;
         freq_sh_q  <= '0;
         acc_q      <= '0;
         pipe_q     <= '0;
         cnt_q      <= '0;
         ovr_q      <= '0;
         ad_start_q <= '0;
      end else begin
         armed_q    <= armed_d;
         thr_q      <= thr_d;
         freq_sh_q  <= freq_sh_d;
         acc_q      <= acc_d;
         pipe_q     <= pipe_d;
         cnt_q      <= cnt_d;
         ovr_q      <= ovr_d;
         ad_start_q <= ad_start_d;
      end
   end

   assign ad_start = ad_start_q;
   assign armed    = armed_q;
   assign ovr      = ovr_q;

endmodule

// File: tb/tb_ad_start_sched.sv
// Bench for ad_start_sched: directed scenarios then random segments, checked
// cycle by cycle through a queue fed by a fire-time reference model.
module tb_ad_start_sched;

   localparam int NCH   = 4;
   localparam int FW    = 16;
   localparam int S     = 3;
   localparam int W     = 2;
   localparam int SC    = 10;
   localparam int TRUNC = 0;
   localparam int MAXC  = 60000;

   logic                clk;
   logic                rst;
   logic                phase_valid;
   logic [31:0]         phase_cnt;
   logic                ad_en;
   logic [NCH-1:0]      ch_en;
   logic [NCH*FW-1:0]   reg_freq;
   logic [NCH-1:0]      ad_start;
   logic                armed;
   logic [NCH-1:0]      ovr;

   ad_start_sched #(
      .N_CH(NCH), .FREQ_W(FW), .PH_W(32), .SCALE(SC), .TRUNC(TRUNC),
      .START_DLY(S), .PULSE_W(W)
   ) dut (
      .clk(clk), .rst(rst), .phase_valid(phase_valid), .phase_cnt(phase_cnt),
      .ad_en(ad_en), .ch_en(ch_en), .reg_freq(reg_freq),
      .ad_start(ad_start), .armed(armed), .ovr(ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int             n;
      logic [NCH-1:0] st;
      logic           arm;
      logic [NCH-1:0] ov;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   seg = 0;

   // Stimulus configuration
   bit          en_v = 0;
   logic [3:0]  chen_v = '0;
   logic [15:0] freq_v [NCH];
   int          per_v = 1000;
   int          pc_v = 1000;
   int          cd = 0;
   bit          strobe_en = 0;

   // Reference model: fire times from sample counts since each channel's last realignment
   bit     fh [NCH][MAXC];
   int     n = 0;
   int     clr = -1;
   longint thr = 0;
   longint fsh [NCH];
   int     base [NCH];
   bit     m_armed = 0;
   bit     movr [NCH];

   function automatic bit fired(int i, int c);
      if (c < 0 || c <= clr) return 1'b0;
      return fh[i][c];
   endfunction

   task automatic model_step();
      exp_t   e;
      longint k;
      e.n = n; e.st = '0; e.arm = 1'b0; e.ov = '0;
      if (rst || !ad_en) begin
         m_armed = 0;
         clr = n;
         for (int i = 0; i < NCH; i++) begin
            movr[i] = 0;
            fh[i][n] = 0;
         end
      end else begin
         if (phase_valid) begin
            thr = longint'((phase_cnt >> TRUNC) << TRUNC) * SC;
            m_armed = 1;
            for (int i = 0; i < NCH; i++) begin
               fsh[i]   = longint'(reg_freq[i*FW +: FW]);
               base[i]  = n;
               fh[i][n] = ch_en[i] && fsh[i] != 0 && thr != 0;
            end
         end else if (m_armed) begin
            for (int i = 0; i < NCH; i++) begin
               fh[i][n] = 0;
               if (ch_en[i] && fsh[i] != 0 && thr != 0) begin
                  if (fsh[i] >= thr) begin
                     fh[i][n] = 1;
                     base[i]  = n;
                     movr[i]  = 1;
                  end else begin
                     k = longint'(n - base[i]);
                     fh[i][n] = ((k * fsh[i]) / thr) != (((k - 1) * fsh[i]) / thr);
                  end
               end else begin
                  base[i] = n;
               end
            end
         end else begin
            for (int i = 0; i < NCH; i++) fh[i][n] = 0;
         end
         for (int i = 0; i < NCH; i++) begin
            // Pulse of fire c spans cycles c+S .. c+S+W-1; a fire whose start
            // meets a still-high pulse is an overrun.
            if (fired(i, n - S + 1)) begin
               for (int j = 1; j <= W; j++) begin
                  if (fired(i, n - S + 1 - j)) movr[i] = 1;
               end
            end
            for (int c = n + 2 - S - W; c <= n + 1 - S; c++) begin
               if (fired(i, c)) e.st[i] = 1'b1;
            end
            e.ov[i] = movr[i];
         end
         e.arm = m_armed;
      end
      exp_q.push_back(e);
      n++;
   endtask

   task automatic cycle(input bit r, input bit pv, input logic [31:0] pc);
      @(negedge clk);
      rst         = r;
      phase_valid = pv;
      phase_cnt   = pc;
      ad_en       = en_v;
      ch_en       = chen_v;
      for (int i = 0; i < NCH; i++) reg_freq[i*FW +: FW] = freq_v[i];
      model_step();
   endtask

   task automatic run(input int ncyc);
      bit pv;
      for (int t = 0; t < ncyc; t++) begin
         pv = strobe_en && (cd == 0);
         if (strobe_en) cd = (cd == 0) ? per_v - 1 : cd - 1;
         cycle(1'b0, pv, pv ? 32'(pc_v) : 32'($urandom()));
      end
   endtask

   // Monitor: compare every presented output word against the queued expectation
   int last_rise0 = -1;
   bit prev0 = 0;
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ad_start !== e.st || armed !== e.arm || ovr !== e.ov) begin
               errors++;
               $display("FAIL outputs cyc=%0d: got ad_start=%b armed=%b ovr=%b, want ad_start=%b armed=%b ovr=%b",
                        e.n, ad_start, armed, ovr, e.st, e.arm, e.ov);
            end
            if (ad_start[0] === 1'b1 && !prev0) begin
               if (seg == 1 && last_rise0 >= 0) begin
                  checks++;
                  if (e.n - last_rise0 != 200) begin
                     errors++;
                     $display("FAIL ch0_spacing cyc=%0d: got %0d, want 200", e.n, e.n - last_rise0);
                  end
               end
               last_rise0 = e.n;
            end
            prev0 = (ad_start[0] === 1'b1);
         end
      end
   end

   initial begin
      int r;
      int thrl;
      rst = 1'b1; phase_valid = 1'b0; phase_cnt = '0; ad_en = 1'b0; ch_en = '0; reg_freq = '0;
      for (int i = 0; i < NCH; i++) freq_v[i] = '0;

      repeat (3) cycle(1'b1, 1'b0, 32'd0);

      // Enabled but no strobe: stays disarmed
      en_v = 1; chen_v = 4'b1111; strobe_en = 0;
      run(20);

      // Basic and fractional rates; ch3 disabled
      freq_v[0] = 16'd50; freq_v[1] = 16'd35; freq_v[2] = 16'd0; freq_v[3] = 16'd70;
      chen_v = 4'b0111; per_v = 1000; pc_v = 1000; cd = 0; strobe_en = 1;
      last_rise0 = -1; seg = 1;
      run(3000);
      seg = 0;

      // Shadow update mid-period
      run(500);
      freq_v[0] = 16'd100;
      run(1500);

      // Overrun on ch2, then ch3 enabled
      freq_v[2] = 16'd20000;
      run(1200);
      chen_v = 4'b1111;
      run(1000);

      // Drop ad_en while ch2 is continuously high
      en_v = 0; run(5); en_v = 1;
      run(600);

      // Reset mid-pulse; no output until re-armed by a strobe
      cycle(1'b1, 1'b0, 32'd0);
      strobe_en = 0; run(30);
      cd = 0; strobe_en = 1; run(500);

      // Zero-period strobe idles every channel
      pc_v = 0; cd = 0; run(300); pc_v = 1000;

      // Random segments
      for (int s = 0; s < 40; s++) begin
         per_v = $urandom_range(5, 300);
         r = $urandom_range(0, 9);
         if (r == 0) pc_v = 0;
         else if (r < 3) pc_v = $urandom_range(1, 400);
         else pc_v = per_v;
         thrl = pc_v * SC;
         for (int i = 0; i < NCH; i++) begin
            r = $urandom_range(0, 5);
            if (r == 0 || thrl == 0) freq_v[i] = 16'($urandom_range(0, 3));
            else if (r == 1) freq_v[i] = 16'($urandom_range(thrl, 65535));
            else freq_v[i] = 16'($urandom_range(1, (thrl > 1) ? thrl - 1 : 1));
         end
         chen_v = 4'($urandom());
         r = $urandom_range(0, 7);
         if (r == 0) begin
            en_v = 0; run($urandom_range(1, 3)); en_v = 1;
         end else if (r == 1) begin
            repeat ($urandom_range(1, 2)) cycle(1'b1, 1'b0, 32'd0);
         end
         run($urandom_range(50, 600));
      end

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ad_start_sched.md
Name: ad_start_sched

Overview:
- Parametrised successor of the per-channel AD sample-start generator.
- Produces N_CH independent ADC start pulses. Each pulse train is phase-locked to the phase-detector strobe.
- Each channel's sample rate is set as a fixed-point ratio of the measured phase period. A multiplier-free accumulator (DDA) gives drift-free spacing.
- Adds per-channel enable, shadowed rate registers, configurable pulse delay/width, and overrun status.
- Sits between the phase-period counter and the AD front-end interface.

Parameters:
- N_CH, 4, number of AD channels.
- FREQ_W, 16, width of each channel rate word.
- PH_W, 32, width of the phase-period count.
- SCALE, 10, rate units per sample per period; rate word = samples-per-period × SCALE.
- TRUNC, 0, low bits of phase_cnt forced to 0 before use; 9 reproduces the legacy resolution.
- START_DLY, 3, cycles from fire event to first ad_start high.
- PULSE_W, 2, ad_start high time in cycles (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- phase_valid  in  1  one-cycle strobe at each phase-detector edge.
- phase_cnt  in  PH_W  period length in clk cycles; sampled only when phase_valid=1.
- ad_en  in  1  global enable; low disarms all channels.
- ch_en  in  N_CH  per-channel enable.
- reg_freq  in  N_CH*FREQ_W  rate words; channel i occupies bits [i*FREQ_W +: FREQ_W].
- ad_start  out  N_CH  start pulses to the ADCs.
- armed  out  1  high once locked to a phase strobe.
- ovr  out  N_CH  sticky overrun flag per channel.

Behaviour:
- Reset (rst=1 at a clk edge) clears: armed, ad_start, ovr, all accumulators, shadows, delay lines and stretch counters.
- Arming:
  - ad_en=0 forces armed=0, clears accumulators/delay lines, ad_start=0, ovr=0.
  - With ad_en=1, the first phase_valid sets armed on the next edge; that same strobe counts as a phase event.
- Phase event (phase_valid=1 while ad_en=1):
  - Shadow period_r <= phase_cnt with the low TRUNC bits cleared.
  - Shadow freq_sh[i] <= reg_freq slice.
  - Every acc[i] <= 0.
  - Every enabled channel with a non-zero new freq_sh and non-zero new threshold fires this cycle (phase-aligned sample).
  - Rate changes therefore take effect only at phase events.
- Threshold: T = period_r × SCALE, width PH_W+$clog2(SCALE)+1, computed once per phase event (registered). SCALE is a constant, so a shift-add or constant multiply is acceptable.
- Per cycle, channel i, armed, ch_en[i]=1, no phase event:
  - freq_sh=0 or T=0: no fire, acc held at 0.
  - freq_sh ≥ T: fire every cycle, acc=0, ovr[i] set.
  - Else if acc+freq_sh ≥ T: fire, acc <= acc+freq_sh−T.
  - Else acc <= acc+freq_sh.
  - Phase event has priority; at most one fire per channel per cycle.
- Channel disable: ch_en[i]=0 holds acc[i] at 0 and suppresses new fires. Pulses already in the delay line complete.
- Pulse shaping:
  - A fire at cycle c drives ad_start[i] high during cycles c+START_DLY … c+START_DLY+PULSE_W−1.
  - Implementation: START_DLY-deep shift register, then a stretch counter.
  - A delayed fire arriving while the stretch counter is non-zero restarts the counter (pulses merge) and sets ovr[i].
- ovr is sticky; cleared only by rst or ad_en=0.
- A phase_valid arriving with phase_cnt=0 sets T=0: all channels idle until the next valid strobe.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Basic rate:
  - Stimulus: rst, ad_en=1, ch_en=1, TRUNC=0, reg_freq ch0=50; phase_valid every 1000 cycles, phase_cnt=1000.
  - Required: ch0 fires at c, c+200, c+400, c+600, c+800 (5 per period). ad_start[0] is high at c+3 and c+4 after each fire. Next strobe re-aligns with no sixth pulse.
- Fractional rate:
  - Stimulus: ch1=35, same period.
  - Required: fires spaced 285/286 cycles (3 pulses per period plus the phase-aligned one). No drift across 10 periods. acc resets at every strobe.
- Shadow update:
  - Stimulus: change ch0 from 50 to 100 mid-period.
  - Required: spacing stays 200 until the next strobe, then becomes 100.
- Overrun:
  - Stimulus: ch2=20000 with T=10000.
  - Required: fire every cycle, ad_start[2] continuously high after 3 cycles, ovr[2]=1. ovr clears only on ad_en=0.
- Enable/arming:
  - Stimulus: ad_en=1 with no strobe.
  - Required: armed=0, ad_start=0.
  - Stimulus: ch_en[3]=0.
  - Required: ad_start[3] never asserts.
  - Stimulus: drop ad_en mid-pulse.
  - Required: ad_start=0 and armed=0 on the next edge.
- Reset mid-operation:
  - Stimulus: rst during an active pulse.
  - Required: all outputs 0 on the next edge. No pulse until ad_en=1 and a new phase_valid.
